// File: rtl/uart_tx_buffered_if.sv
// Write-side bus of the buffered UART transmitter: byte strobe in, FIFO status out.
// The producer takes the master modport, the transmitter the slave modport.
interface uart_tx_buffered_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  count,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output count,
        output overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a circular FIFO so characters arriving mid-frame are
// queued rather than lost; only writes into a full FIFO are dropped (and flagged).
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DEPTH        = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_buffered_if.slave wr,
    output logic              tx_serial,
    output logic              tx_active,
    output logic              tx_done
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;
    logic              done_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              bit_tick;

    // full comes from the registered count, so a pop in the same cycle cannot rescue a write
    assign full     = (count == CNT_W'(DEPTH));
    assign push     = wr.wr_en && !full;
    assign pop      = (state == IDLE) && (count != '0);
    assign bit_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    assign wr.full     = full;
    assign wr.count    = count;
    assign wr.overflow = overflow;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (count != '0) next_state = START;
            START:   if (bit_tick) next_state = DATA;
            DATA:    if (bit_tick && bit_cnt == 3'd7) next_state = STOP;
            STOP:    if (bit_tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            done_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                shift_reg <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr.wr_en && full) begin
                overflow <= 1'b1;
            end
            // Registered so the pulse lands in the first IDLE cycle after the stop bit
            done_q <= (state == STOP) && bit_tick;
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                baud_cnt <= bit_tick ? '0 : baud_cnt + BAUD_W'(1);
                if (state == DATA && bit_tick) begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        tx_serial = 1'b1;
        tx_active = 1'b0;
        case (state)
            START: begin
                tx_serial = 1'b0;
                tx_active = 1'b1;
            end
            DATA: begin
                tx_serial = shift_reg[0];
                tx_active = 1'b1;
            end
            STOP: begin
                tx_serial = 1'b1;
                tx_active = 1'b1;
            end
            default: begin
                tx_serial = 1'b1;
                tx_active = 1'b0;
            end
        endcase
        tx_done = done_q;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: writes queue expected bytes, a line monitor
// decodes every frame cycle-by-cycle and compares against the queue head.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_serial;
    logic tx_active;
    logic tx_done;

    uart_tx_buffered_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(bus.slave),
        .tx_serial(tx_serial),
        .tx_active(tx_active),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    int         start_q[$];
    int         done_q[$];
    int         frames_seen = 0;
    int         max_count = 0;
    bit         track_max = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        if (accept) sb_q.push_back(data);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && tx_active === 1'b0 && bus.count === '0) && n < limit) begin
            tick();
            n++;
        end
        checkOutput({name, "_drain_timeout"}, 32'(n >= limit), 32'd0);
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (track_max && int'(bus.count) > max_count) max_count = int'(bus.count);
    end

    // Line monitor: checks every cycle of a frame against the expected byte
    logic [7:0] m_exp;
    logic [7:0] m_rx;
    logic       m_line;
    int         m_bad;
    bit         m_abort;
    bit         m_have;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_serial === 1'b0) begin
                start_q.push_back(cyc);
                frames_seen++;
                m_have = (sb_q.size() > 0);
                if (m_have) begin
                    m_exp = sb_q.pop_front();
                end else begin
                    m_exp = 8'h00;
                    checkOutput("unexpected_frame", 32'd1, 32'd0);
                end
                m_bad   = -1;
                m_abort = 1'b0;
                m_rx    = 8'h00;
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        m_abort = 1'b1;
                        break;
                    end
                    if (k < CPB) m_line = 1'b0;
                    else if (k < 9 * CPB) m_line = m_exp[(k - CPB) / CPB];
                    else m_line = 1'b1;
                    if (m_bad < 0 && (tx_serial !== m_line || tx_active !== 1'b1 || tx_done !== 1'b0))
                        m_bad = k;
                    if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2)
                        m_rx[(k - CPB) / CPB] = tx_serial;
                end
                if (!m_abort) begin
                    @(negedge clk);
                    if (!rst) begin
                        done_q.push_back(cyc);
                        checkOutput("frame_done_active", {30'd0, tx_done, tx_active}, 32'd2);
                        if (m_have) checkOutput("frame_byte", {24'd0, m_rx}, {24'd0, m_exp});
                        checkOutput("frame_first_bad_cycle", m_bad, -1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run exceeded time limit, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] wrap_bytes [12];
    int  n;
    int  f0;
    bit  line_ok;
    bit  done_seen;

    initial begin
        wrap_bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'h81, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        rst         = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("reset_tx_active", 32'(tx_active), 32'd0);
        checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
        checkOutput("reset_full", 32'(bus.full), 32'd0);
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("[TB] single byte 0x41");
        start_q.delete();
        done_q.delete();
        n = cyc;
        applyStimulus(8'h41, 1'b1);
        @(negedge clk);
        checkOutput("single_count_n1", 32'(bus.count), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("single_count_n2", 32'(bus.count), 32'd0);
        checkOutput("single_active_n2", 32'(tx_active), 32'd1);
        checkOutput("single_serial_n2", 32'(tx_serial), 32'd0);
        drain("single", 100);
        checkOutput("single_frames", start_q.size(), 32'd1);
        checkOutput("single_start_cycle", (start_q.size() > 0) ? start_q[0] : -1, n + 2);
        checkOutput("single_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, n + 42);

        $display("[TB] burst of 5");
        start_q.delete();
        n = cyc;
        for (int i = 0; i < 5; i++) applyStimulus(8'h41 + 8'(i), 1'b1);
        @(negedge clk);
        checkOutput("burst_full", 32'(bus.full), 32'd1);
        drain("burst", 300);
        checkOutput("burst_frames", start_q.size(), 32'd5);
        checkOutput("burst_first_start", (start_q.size() > 0) ? start_q[0] : -1, n + 2);
        if (start_q.size() == 5) begin
            for (int i = 1; i < 5; i++)
                checkOutput("burst_start_spacing", start_q[i] - start_q[i-1], 32'd41);
        end
        checkOutput("burst_overflow", 32'(bus.overflow), 32'd0);

        $display("[TB] write in pop cycle");
        n = cyc;
        applyStimulus(8'h3C, 1'b1);
        wait_cycle(n + 10);
        applyStimulus(8'hC3, 1'b1);
        wait_cycle(n + 42);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h96;
        sb_q.push_back(8'h96);
        @(negedge clk);
        checkOutput("simul_done_at_pop", 32'(tx_done), 32'd1);
        checkOutput("simul_count_before", 32'(bus.count), 32'd1);
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        checkOutput("simul_count_after", 32'(bus.count), 32'd1);
        checkOutput("simul_active_after", 32'(tx_active), 32'd1);
        drain("simul", 300);

        $display("[TB] wrap-around stream");
        done_q.delete();
        max_count = 0;
        track_max = 1'b1;
        n = cyc;
        for (int i = 0; i < 12; i++) begin
            wait_cycle(n + 50 * i);
            applyStimulus(wrap_bytes[i], 1'b1);
        end
        drain("wrap", 200);
        track_max = 1'b0;
        checkOutput("wrap_frames", done_q.size(), 32'd12);
        checkOutput("wrap_max_count_le2", 32'(max_count <= 2), 32'd1);

        $display("[TB] overflow");
        f0 = frames_seen;
        n = cyc;
        for (int i = 0; i < 5; i++) applyStimulus(8'h61 + 8'(i), 1'b1);
        @(negedge clk);
        checkOutput("ovf_full", 32'(bus.full), 32'd1);
        checkOutput("ovf_flag_before", 32'(bus.overflow), 32'd0);
        applyStimulus(8'h66, 1'b0);
        @(negedge clk);
        checkOutput("ovf_flag_after", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_count", 32'(bus.count), 32'd4);
        drain("ovf", 300);
        checkOutput("ovf_frames", frames_seen - f0, 32'd5);
        checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);

        $display("[TB] reset mid-frame");
        n = cyc;
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h42, 1'b1);
        applyStimulus(8'h43, 1'b1);
        wait_cycle(n + 15);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_tx_active", 32'(tx_active), 32'd0);
        tick();
        rst = 1'b0;
        sb_q.delete();
        line_ok   = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) line_ok = 1'b0;
            if (tx_done !== 1'b0) done_seen = 1'b1;
        end
        checkOutput("rst_line_idle", 32'(line_ok), 32'd1);
        checkOutput("rst_no_done", 32'(done_seen), 32'd0);
        checkOutput("rst_overflow_cleared", 32'(bus.overflow), 32'd0);
        checkOutput("rst_full_cleared", 32'(bus.full), 32'd0);
        tick();
        applyStimulus(8'h5A, 1'b1);
        drain("post_rst", 100);
        checkOutput("final_queue_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
